// File: rtl/uop_cache_arbiter.sv
// Single-port uop-cache BRAM arbiter: replay reads, capture writes, and an invalidation sweep.
// Optional stall counters are enabled by defining UOPC_ARB_STATS_EN.
module uop_cache_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int STEP     = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              inv_start,
    output logic              inv_busy,
    output logic              inv_done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [15:0]       stat_rd_stall,
    output logic [15:0]       stat_wr_stall
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, SERVE, INVALIDATE} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    ptr, ptr_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                vld_p1;
    logic                promote;
    logic [ADDR_W-1:0]   sweep_addr;

    assign sweep_addr = ADDR_W'(32'(ptr) * 32'(STEP));
    assign promote    = wr_req && (wait_cnt == WAIT_W'(MAX_WAIT));
    assign rd_valid   = vld_p1;
    assign rd_data    = bram_rdata;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        wr_gnt     = 1'b0;
        rd_gnt     = 1'b0;
        inv_busy   = 1'b0;
        inv_done   = 1'b0;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        // Outputs are forced quiet while reset is held, even if requests are high.
        if (reset) begin
            if (inv_start) begin
                state_nxt = INVALIDATE;
                ptr_nxt   = '0;
                inv_busy  = (state == INVALIDATE);
            end else if (state == INVALIDATE) begin
                inv_busy  = 1'b1;
                bram_en   = 1'b1;
                bram_we   = 1'b1;
                bram_addr = sweep_addr;
                if (ptr == PTR_W'(DEPTH - 1)) begin
                    inv_done  = 1'b1;
                    ptr_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end else begin
                state_nxt = (rd_req || wr_req) ? SERVE : IDLE;
                if (wr_req && (!rd_req || promote)) begin
                    wr_gnt     = 1'b1;
                    bram_en    = 1'b1;
                    bram_we    = 1'b1;
                    bram_addr  = wr_addr;
                    bram_wdata = wr_data;
                end else if (rd_req) begin
                    rd_gnt    = 1'b1;
                    bram_en   = 1'b1;
                    bram_addr = rd_addr;
                end
            end
        end
    end

    // Consecutive-denial count; saturates so writes held off by a sweep are promoted afterwards.
    always_comb begin
        wait_nxt = wait_cnt;
        if (!wr_req || wr_gnt)
            wait_nxt = '0;
        else if (wait_cnt != WAIT_W'(MAX_WAIT))
            wait_nxt = wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            wait_cnt <= '0;
            vld_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            wait_cnt <= wait_nxt;
            vld_p1   <= rd_gnt;
        end
    end

`ifdef UOPC_ARB_STATS_EN
    logic [15:0] rd_stall_q, wr_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_stall_q <= '0;
            wr_stall_q <= '0;
        end else begin
            if (rd_req && !rd_gnt && (rd_stall_q != 16'hFFFF))
                rd_stall_q <= rd_stall_q + 16'd1;
            if (wr_req && !wr_gnt && (wr_stall_q != 16'hFFFF))
                wr_stall_q <= wr_stall_q + 16'd1;
        end
    end

    assign stat_rd_stall = rd_stall_q;
    assign stat_wr_stall = wr_stall_q;
`else
    assign stat_rd_stall = 16'd0;
    assign stat_wr_stall = 16'd0;
`endif

endmodule

// File: tb/tb_uop_cache_arbiter.sv
// Self-checking bench for uop_cache_arbiter: directed table, sweep sequences, random run vs model.
module tb_uop_cache_arbiter;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 64;
    localparam int STEP     = 8;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_req, rd_req, inv_start;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, bram_rdata;
    logic              wr_gnt, rd_gnt, rd_valid, inv_busy, inv_done;
    logic              bram_en, bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata, rd_data;
    logic [15:0]       stat_rd_stall, stat_wr_stall;

    always #5 clk = ~clk;

    uop_cache_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STEP(STEP), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .inv_start(inv_start), .inv_busy(inv_busy), .inv_done(inv_done),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .stat_rd_stall(stat_rd_stall), .stat_wr_stall(stat_wr_stall)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: sweep progress, consecutive write denials, last read grant, stall totals.
    bit m_sweeping;
    int m_ptr, m_denied, m_rs, m_ws;
    bit m_last_rd;

    task automatic model_reset();
        m_sweeping = 0; m_ptr = 0; m_denied = 0; m_last_rd = 0; m_rs = 0; m_ws = 0;
    endtask

    // Values captured during the most recent apply(), for table and sequence checks.
    logic s_wg, s_rg, s_en, s_we, s_rv, s_busy, s_done;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wd, s_rdata;

    task automatic apply(input logic wrq, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic rdq, input logic [ADDR_W-1:0] ra,
                         input logic [DATA_W-1:0] rdat, input logic inv);
        bit e_wg, e_rg, e_en, e_we, e_busy, e_done;
        int e_addr, e_wd;
        @(negedge clk);
        wr_req = wrq; wr_addr = wa; wr_data = wd;
        rd_req = rdq; rd_addr = ra; bram_rdata = rdat; inv_start = inv;
        #1;
        e_wg = 0; e_rg = 0; e_en = 0; e_we = 0; e_busy = 0; e_done = 0; e_addr = 0; e_wd = 0;
        if (inv) begin
            e_busy = m_sweeping;
        end else if (m_sweeping) begin
            e_busy = 1; e_en = 1; e_we = 1;
            e_addr = (m_ptr * STEP) % (1 << ADDR_W);
            e_done = (m_ptr == DEPTH - 1);
        end else if (wrq && (!rdq || m_denied >= MAX_WAIT)) begin
            e_wg = 1; e_en = 1; e_we = 1; e_addr = int'(wa); e_wd = int'(wd);
        end else if (rdq) begin
            e_rg = 1; e_en = 1; e_addr = int'(ra);
        end
        s_wg = wr_gnt; s_rg = rd_gnt; s_en = bram_en; s_we = bram_we; s_rv = rd_valid;
        s_busy = inv_busy; s_done = inv_done; s_addr = bram_addr; s_wd = bram_wdata; s_rdata = rd_data;
        chk("wr_gnt", 32'(wr_gnt), 32'(e_wg));
        chk("rd_gnt", 32'(rd_gnt), 32'(e_rg));
        chk("bram_en", 32'(bram_en), 32'(e_en));
        chk("bram_we", 32'(bram_we), 32'(e_we));
        chk("bram_addr", 32'(bram_addr), 32'(e_addr));
        chk("bram_wdata", 32'(bram_wdata), 32'(e_wd));
        chk("rd_valid", 32'(rd_valid), 32'(m_last_rd));
        chk("rd_data", 32'(rd_data), 32'(rdat));
        chk("inv_busy", 32'(inv_busy), 32'(e_busy));
        chk("inv_done", 32'(inv_done), 32'(e_done));
`ifdef UOPC_ARB_STATS_EN
        chk("stat_rd_stall", 32'(stat_rd_stall), 32'(m_rs));
        chk("stat_wr_stall", 32'(stat_wr_stall), 32'(m_ws));
`else
        chk("stat_rd_stall", 32'(stat_rd_stall), 32'd0);
        chk("stat_wr_stall", 32'(stat_wr_stall), 32'd0);
`endif
        @(posedge clk);
        if (rdq && !e_rg && m_rs < 65535) m_rs++;
        if (wrq && !e_wg && m_ws < 65535) m_ws++;
        m_denied  = (!wrq || e_wg) ? 0 : ((m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT);
        m_last_rd = e_rg;
        if (inv) begin
            m_sweeping = 1; m_ptr = 0;
        end else if (m_sweeping) begin
            if (m_ptr == DEPTH - 1) begin m_sweeping = 0; m_ptr = 0; end
            else m_ptr++;
        end
    endtask

    task automatic idle(input logic wrq, input logic rdq);
        apply(wrq, 9'h040, 32'h0000_00AA, rdq, 9'h030, 32'h1234_5678, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic              wrq;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              rdq;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        logic              e_wg, e_rg, e_en, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        logic              e_rv;
    } vec_t;

    vec_t tbl[10];
    int busy_cnt, done_cnt, done_idx;

    initial begin
        reset = 1'b0; wr_req = 0; rd_req = 0; inv_start = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; bram_rdata = '0;
        model_reset();

        //             wrq wa      wd            rdq ra      rdat          wg rg en we addr    wd            rv
        tbl[0] = '{1'b0, 9'h000, 32'h0,        1'b1, 9'h020, 32'hDEADBEEF, 0, 1, 1, 0, 9'h020, 32'h0,        0};
        tbl[1] = '{1'b0, 9'h000, 32'h0,        1'b0, 9'h000, 32'hDEADBEEF, 0, 0, 0, 0, 9'h000, 32'h0,        1};
        tbl[2] = '{1'b1, 9'h008, 32'h13,       1'b0, 9'h000, 32'h0,        1, 0, 1, 1, 9'h008, 32'h13,       0};
        tbl[3] = '{1'b1, 9'h040, 32'hAA,       1'b1, 9'h030, 32'h0,        0, 1, 1, 0, 9'h030, 32'h0,        0};
        tbl[4] = '{1'b1, 9'h040, 32'hAA,       1'b1, 9'h030, 32'h0,        0, 1, 1, 0, 9'h030, 32'h0,        1};
        tbl[5] = '{1'b1, 9'h040, 32'hAA,       1'b1, 9'h030, 32'h0,        0, 1, 1, 0, 9'h030, 32'h0,        1};
        tbl[6] = '{1'b1, 9'h040, 32'hAA,       1'b1, 9'h030, 32'h0,        0, 1, 1, 0, 9'h030, 32'h0,        1};
        tbl[7] = '{1'b1, 9'h040, 32'hAA,       1'b1, 9'h030, 32'h0,        1, 0, 1, 1, 9'h040, 32'hAA,       1};
        tbl[8] = '{1'b1, 9'h040, 32'hAA,       1'b1, 9'h030, 32'h0,        0, 1, 1, 0, 9'h030, 32'h0,        0};
        tbl[9] = '{1'b0, 9'h000, 32'h0,        1'b0, 9'h000, 32'h0,        0, 0, 0, 0, 9'h000, 32'h0,        1};

        #12;
        chk("reset_bram_en", 32'(bram_en), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_inv_busy", 32'(inv_busy), 32'd0);
        chk("reset_stat_wr", 32'(stat_wr_stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].wrq, tbl[i].wa, tbl[i].wd, tbl[i].rdq, tbl[i].ra, tbl[i].rdat, 1'b0);
            chk($sformatf("tbl%0d_wr_gnt", i), 32'(s_wg), 32'(tbl[i].e_wg));
            chk($sformatf("tbl%0d_rd_gnt", i), 32'(s_rg), 32'(tbl[i].e_rg));
            chk($sformatf("tbl%0d_en", i), 32'(s_en), 32'(tbl[i].e_en));
            chk($sformatf("tbl%0d_we", i), 32'(s_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_wdata", i), 32'(s_wd), tbl[i].e_wd);
            chk($sformatf("tbl%0d_rd_valid", i), 32'(s_rv), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_rd_data", i), s_rdata, tbl[i].rdat);
        end

        // Stall counters: write denied three cycles by continuous reads.
        do_reset();
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
`ifdef UOPC_ARB_STATS_EN
        chk("stat_wr_after3", 32'(stat_wr_stall), 32'd3);
`else
        chk("stat_wr_after3", 32'(stat_wr_stall), 32'd0);
`endif
        chk("stat_rd_after3", 32'(stat_rd_stall), 32'd0);

        // Full sweep with both requesters held off throughout.
        do_reset();
        apply(1'b1, 9'h040, 32'hAA, 1'b1, 9'h030, 32'h0, 1'b1);
        chk("inv_start_no_access", 32'(s_en), 32'd0);
        busy_cnt = 0; done_cnt = 0; done_idx = -1;
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b1, 1'b1);
            if (s_busy) busy_cnt++;
            if (s_done) begin done_cnt++; done_idx = i; end
            chk("sweep_addr", 32'(s_addr), 32'((i * STEP) % 512));
        end
        chk("sweep_busy_cycles", busy_cnt, DEPTH);
        chk("sweep_done_count", done_cnt, 1);
        chk("sweep_done_pos", done_idx, DEPTH - 1);
        idle(1'b1, 1'b1);
        chk("post_sweep_promoted_wr", 32'(s_wg), 32'd1);

        // Restart at ptr=10: no done for the aborted sweep.
        apply(1'b0, 9'h0, 32'h0, 1'b0, 9'h0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) idle(1'b0, 1'b0);
        apply(1'b0, 9'h0, 32'h0, 1'b0, 9'h0, 32'h0, 1'b1);
        done_cnt = 0; done_idx = -1;
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b0, 1'b1);
            if (i == 0) chk("restart_addr0", 32'(s_addr), 32'd0);
            if (s_done) begin done_cnt++; done_idx = i; end
        end
        chk("restart_done_count", done_cnt, 1);
        chk("restart_done_pos", done_idx, DEPTH - 1);

        // Reset asserted mid-sweep at ptr=20.
        apply(1'b0, 9'h0, 32'h0, 1'b0, 9'h0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) idle(1'b0, 1'b0);
        @(negedge clk);
        wr_req = 0; rd_req = 0; inv_start = 0;
        reset = 1'b0;
        #1;
        chk("midreset_en", 32'(bram_en), 32'd0);
        chk("midreset_we", 32'(bram_we), 32'd0);
        chk("midreset_addr", 32'(bram_addr), 32'd0);
        chk("midreset_busy", 32'(inv_busy), 32'd0);
        chk("midreset_done", 32'(inv_done), 32'd0);
        chk("midreset_rd_valid", 32'(rd_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(1'b0, 1'b1);
        chk("after_reset_rd_gnt", 32'(s_rg), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            apply(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom,
                  1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom,
                  1'($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uop_cache_arbiter.md
Name: uop_cache_arbiter

Overview:
Arbitrates the single-port loop-buffer BRAM (uop cache) between three requesters: the capture path (writes during BUFFERING), the replay path (reads during REUSE), and an invalidation sequencer that zeroes every entry after a mispredict flush or fence. It sits between the loop-buffer FSM and the BRAM instance. It owns all BRAM enable, write-enable and address signals.

Parameters:
ADDR_W, 9, BRAM address width
DATA_W, 32, instruction word width
DEPTH, 64, number of entries swept by invalidation
STEP, 8, address stride between consecutive entries
MAX_WAIT, 4, consecutive denied write-request cycles before write is promoted

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
wr_req  input  1  capture path requests a write this cycle
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_gnt  output  1  write granted this cycle (combinational)
rd_req  input  1  replay path requests a read this cycle
rd_addr  input  ADDR_W  read address
rd_gnt  output  1  read granted this cycle (combinational)
rd_valid  output  1  rd_data valid; registered, one cycle after rd_gnt
rd_data  output  DATA_W  read data, passthrough of bram_rdata
inv_start  input  1  pulse: begin invalidation sweep
inv_busy  output  1  high while a sweep is in progress
inv_done  output  1  one-cycle pulse on the final sweep write
bram_en  output  1  BRAM enable
bram_we  output  1  BRAM write enable
bram_addr  output  ADDR_W  BRAM address
bram_wdata  output  DATA_W  BRAM write data
bram_rdata  input  DATA_W  BRAM read data, one-cycle latency
stat_rd_stall  output  16  read-denied cycle count (optional feature)
stat_wr_stall  output  16  write-denied cycle count (optional feature)

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; sweep pointer 0; starvation counter 0; stat counters 0.
- States: IDLE, SERVE, INVALIDATE.
- IDLE -> SERVE when rd_req|wr_req. IDLE/SERVE -> INVALIDATE on inv_start. SERVE -> IDLE when there is no request and no inv_start. INVALIDATE -> IDLE after the last entry is written.
- inv_start has priority over any same-cycle request. That cycle grants nothing and does no BRAM access; the sweep begins next cycle.
- SERVE priority is read over write, so replay never bubbles.
  - Exception: after wr_req has been denied MAX_WAIT consecutive cycles, the next cycle grants write and denies read.
  - The starvation counter clears on any wr_gnt or when wr_req drops.
- Write grant: bram_en=1, bram_we=1, bram_addr=wr_addr, bram_wdata=wr_data.
- Read grant: bram_en=1, bram_we=0, bram_addr=rd_addr.
- rd_valid is the registered rd_gnt. rd_data = bram_rdata unconditionally.
- With no grant: bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0.
- INVALIDATE:
  - Each cycle drives bram_en=1, bram_we=1, bram_wdata=0, bram_addr=ptr*STEP (ADDR_W-bit, truncated on wrap).
  - ptr runs 0..DEPTH-1, so the sweep lasts exactly DEPTH cycles. inv_busy=1 throughout.
  - inv_done=1 in the ptr=DEPTH-1 cycle.
  - wr_gnt=rd_gnt=0 throughout; requests are held off, not dropped.
  - inv_start during INVALIDATE restarts the sweep at ptr=0 next cycle, and inv_done is not pulsed for the aborted sweep.
- rd_valid from a grant issued the cycle before inv_start still asserts.
- Reset asserted mid-sweep: immediate return to IDLE. Entries are left partially cleared; the loop-buffer FSM is also reset, so this is acceptable.

Optional Feature:
UOPC_ARB_STATS_EN
- Defined: stat_rd_stall increments each cycle rd_req=1 and rd_gnt=0; stat_wr_stall increments each cycle wr_req=1 and wr_gnt=0. Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Undefined: both ports exist and are tied to 0; no counter logic is synthesised.

Test Plan:
- Reset, then rd_req=1 rd_addr=0x20 with bram_rdata=0xDEADBEEF -> rd_gnt=1 with bram_addr=0x20, we=0; next cycle rd_valid=1, rd_data=0xDEADBEEF.
- wr_req=1 alone, wr_addr=0x08 wr_data=0x00000013 -> same-cycle wr_gnt=1, bram_we=1, bram_addr=0x08, bram_wdata=0x13.
- rd_req and wr_req both held high, MAX_WAIT=4 -> read granted cycles 1-4, write granted cycle 5, read resumes cycle 6.
- inv_start pulse with DEPTH=64, STEP=8 -> 64 zero-writes at addresses 0x000,0x008,...,0x1F8; inv_busy high 64 cycles; inv_done only on the 0x1F8 cycle; no rd/wr grants meanwhile.
- inv_start re-pulsed at sweep ptr=10 -> next bram_addr=0x000; inv_done appears 64 cycles later, not earlier. Reset at ptr=20 -> all outputs 0 immediately, state IDLE.
- With UOPC_ARB_STATS_EN, wr_req denied 3 cycles by continuous reads -> stat_wr_stall=3, stat_rd_stall=0. Without the macro, both read 0.
